button_event_queue: RTL and testbench

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

---
 rtl/button_event_queue.sv | 116 +++++++++++
 tb/tb_button_event_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Button press/release event queue: pending-bit capture, lowest-index arbitration, FWFT FIFO.
// Optional release events are enabled by defining BTN_RELEASE_EVT_EN.
module button_event_queue #(
    parameter int N_BTN = 25,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_BTN-1:0]         i_pos,
    input  logic [N_BTN-1:0]         i_down,
    output logic                     o_evt_valid,
    input  logic                     i_evt_ready,
    output logic [4:0]               o_evt_idx,
    output logic                     o_evt_rel,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop,
    input  logic                     i_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2*N_BTN-1:0] pend;
    logic [2*N_BTN-1:0] src;
    logic [2*N_BTN-1:0] sel;
    logic [2*N_BTN-1:0] grant;
    logic [N_BTN-1:0]   rel_src;
    logic               sel_any;
    logic [4:0]         gnt_idx;
    logic               gnt_rel;
    logic               push_ok;
    logic               push;
    logic               pop;
    logic               drop_evt;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [5:0]         mem [DEPTH];
    logic [5:0]         head;

`ifdef BTN_RELEASE_EVT_EN
    logic [N_BTN-1:0]   prev_down;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) prev_down <= '0;
        else          prev_down <= i_down;
    end

    assign rel_src   = prev_down & ~i_down;
    assign o_evt_rel = o_evt_valid & head[5];
`else
    logic unused_sig;

    assign rel_src    = '0;
    assign o_evt_rel  = 1'b0;
    assign unused_sig = ^{i_down, head[5]};
`endif

    assign src = {rel_src, i_pos};

    // Lowest set bit wins, so every pending press drains before any release.
    always_comb begin
        sel     = '0;
        sel_any = 1'b0;
        gnt_idx = '0;
        gnt_rel = 1'b0;
        for (int b = 0; b < 2*N_BTN; b++) begin
            if (pend[b] && !sel_any) begin
                sel_any = 1'b1;
                sel[b]  = 1'b1;
                if (b < N_BTN) begin
                    gnt_idx = 5'(b);
                end else begin
                    gnt_idx = 5'(b - N_BTN);
                    gnt_rel = 1'b1;
                end
            end
        end
    end

    assign pop      = o_evt_valid & i_evt_ready;
    assign push_ok  = (o_count < CW'(DEPTH)) | pop;
    assign push     = sel_any & push_ok;
    assign grant    = push ? sel : '0;
    assign drop_evt = |(src & pend & ~grant);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_drop  <= 1'b0;
        end else begin
            pend <= (pend & ~grant) | src;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
            // Set wins over clear when both happen in one cycle.
            if (drop_evt)   o_drop <= 1'b1;
            else if (i_clr) o_drop <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {gnt_rel, gnt_idx};
    end

    assign head        = mem[rd_ptr];
    assign o_evt_valid = (o_count != '0);
    assign o_evt_idx   = o_evt_valid ? head[4:0] : 5'd0;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue (N_BTN=25, DEPTH=8).
// Define BTN_RELEASE_EVT_EN to also exercise release events.
module tb_button_event_queue;

    localparam int N_BTN = 25;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_BTN-1:0]  pos;
    logic [N_BTN-1:0]  down;
    logic              evt_valid;
    logic              evt_ready;
    logic [4:0]        evt_idx;
    logic              evt_rel;
    logic [3:0]        count;
    logic              drop;
    logic              clr;

    int n_checks = 0;
    int n_fail   = 0;

    button_event_queue #(.N_BTN(N_BTN), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pos       (pos),
        .i_down      (down),
        .o_evt_valid (evt_valid),
        .i_evt_ready (evt_ready),
        .o_evt_idx   (evt_idx),
        .o_evt_rel   (evt_rel),
        .o_count     (count),
        .o_drop      (drop),
        .i_clr       (clr)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and samples both sit 1 ns after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int exp_seq [10] = '{1, 2, 4, 6, 9, 11, 13, 15, 20, 24};
    int exp4    [9]  = '{10, 11, 12, 13, 14, 15, 16, 17, 2};

    initial begin
        rst_n = 1'b0; pos = '0; down = '0; evt_ready = 1'b0; clr = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick();
        check("rst_count", count, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_drop",  drop, 0);
        check("rst_idx",   evt_idx, 0);

        // Single press, two-cycle latency, immediate pop
        evt_ready = 1'b1;
        pos = 25'(1) << 3;
        tick();
        pos = '0;
        check("s1_k1_valid", evt_valid, 0);
        tick();
        check("s1_k2_valid", evt_valid, 1);
        check("s1_k2_idx",   evt_idx, 3);
        check("s1_k2_count", count, 1);
        tick();
        check("s1_after_valid", evt_valid, 0);
        check("s1_after_count", count, 0);
        check("s1_after_idx",   evt_idx, 0);

        // Three simultaneous presses queue in index order
        evt_ready = 1'b0;
        pos = 25'h00000A1;
        tick();
        pos = '0;
        tick(4);
        check("s2_count", count, 3);
        check("s2_head0", evt_idx, 0);
        tick();
        check("s2_hold",  evt_idx, 0);
        evt_ready = 1'b1;
        tick();
        check("s2_head5", evt_idx, 5);
        tick();
        check("s2_head7", evt_idx, 7);
        tick();
        check("s2_empty", count, 0);
        evt_ready = 1'b0;

        // Ten presses overflow the FIFO into pending, then drain in order
        pos = '0;
        foreach (exp_seq[i]) pos[exp_seq[i]] = 1'b1;
        tick();
        pos = '0;
        tick(12);
        check("s3_full", count, 8);
        check("s3_nodrop", drop, 0);
        evt_ready = 1'b1;
        foreach (exp_seq[i]) begin
            check($sformatf("s3_head%0d", i), evt_idx, exp_seq[i]);
            check($sformatf("s3_valid%0d", i), evt_valid, 1);
            tick();
        end
        check("s3_empty", count, 0);
        check("s3_drop", drop, 0);
        evt_ready = 1'b0;

        // Fill FIFO, hold button 2 pending, then coalesce it
        pos = 25'h003FC00;
        tick();
        pos = '0;
        tick(9);
        check("s4_full", count, 8);
        pos = 25'(1) << 2;
        tick();
        pos = '0;
        tick();
        check("s4_pend_nodrop", drop, 0);
        pos = 25'(1) << 2;
        tick();
        pos = '0;
        check("s4_drop", drop, 1);
        check("s4_count", count, 8);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("s4_clr", drop, 0);
        clr = 1'b1;
        pos = 25'(1) << 2;
        tick();
        clr = 1'b0;
        pos = '0;
        check("s4_set_wins", drop, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("s4_clr2", drop, 0);
        evt_ready = 1'b1;
        foreach (exp4[i]) begin
            check($sformatf("s4_head%0d", i), evt_idx, exp4[i]);
            tick();
        end
        check("s4_empty", count, 0);
        evt_ready = 1'b0;

        // Re-press in the very cycle the bit is granted: two events, no drop
        pos = 25'(1) << 6;
        tick();
        tick();
        pos = '0;
        tick(2);
        check("grant_same_count", count, 2);
        check("grant_same_drop",  drop, 0);
        evt_ready = 1'b1;
        tick(2);
        check("grant_same_empty", count, 0);
        evt_ready = 1'b0;

`ifdef BTN_RELEASE_EVT_EN
        pos  = 25'(1) << 4;
        down = 25'(1) << 4;
        tick();
        pos = '0;
        tick(4);
        down = '0;
        tick(2);
        check("s5_count", count, 2);
        check("s5_press_idx", evt_idx, 4);
        check("s5_press_rel", evt_rel, 0);
        evt_ready = 1'b1;
        tick();
        check("s5_rel_idx", evt_idx, 4);
        check("s5_rel_rel", evt_rel, 1);
        tick();
        check("s5_empty", count, 0);
        check("s5_rel_idle", evt_rel, 0);
        evt_ready = 1'b0;
`else
        down = 25'(1) << 4;
        tick(2);
        down = '0;
        tick(3);
        check("norel_count", count, 0);
        check("norel_rel", evt_rel, 0);
`endif

        // Reset mid-operation drops queued and pending events
        pos = 25'h000007F;
        tick();
        pos = '0;
        tick(5);
        check("s6_queued", count, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s6_count", count, 0);
        check("s6_valid", evt_valid, 0);
        tick(5);
        check("s6_stale_count", count, 0);
        check("s6_stale_valid", evt_valid, 0);
        check("s6_drop", drop, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
